// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package dcache_port_arbiter_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned WT_W             = 4;
  localparam int unsigned STATE_W          = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Arbiter FSM encoding
  localparam logic [STATE_W-1:0] ARB_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ARB_REQ  = 2'd1;
  localparam logic [STATE_W-1:0] ARB_WAIT = 2'd2;

  // Requester ids
  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_SB  = 1'b1;

  // Request fields latched at grant and driven to the cache
  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic              signed_ext;
    logic [WT_W-1:0]   write_type;
    logic [DATA_W-1:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/dcache_port_arbiter_arb_pick.sv
// Starvation-aware two-port priority pick: port 0 preferred, port 1 wins
// once port 0 has taken STARVE_LIMIT consecutive grants while port 1 waited.
module dcache_port_arbiter_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic arb_en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic grant0_c_o,
  output logic grant1_c_o
);

  localparam int unsigned           CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]      LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved;

  // Grant decision and starvation counter update
  always_comb begin
    starved      = (starve_cnt_q == LIMIT);
    grant1_c_o   = arb_en_i && req1_i && (!req0_i || starved);
    grant0_c_o   = arb_en_i && req0_i && !grant1_c_o;
    starve_cnt_d = starve_cnt_q;
    if (grant1_c_o || (grant0_c_o && !req1_i)) begin
      starve_cnt_d = '0;
    end else if (grant0_c_o && !starved) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the data-cache request port between the LSU (port 0) and the
// store-buffer drain (port 1); one transaction outstanding, flush squashes
// port-0 responses without breaking the cache handshake.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_by_writeback,

  input  logic              req0_valid,
  input  logic              req0_op,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_signed_ext,
  input  logic [WT_W-1:0]   req0_write_type,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,

  input  logic              req1_valid,
  input  logic              req1_op,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_signed_ext,
  input  logic [WT_W-1:0]   req1_write_type,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,

  output logic              valid,
  output logic              op,
  output logic [ADDR_W-1:0] addr,
  output logic              signed_ext,
  output logic [WT_W-1:0]   write_type,
  output logic [DATA_W-1:0] w_data_CPU,
  input  logic              addr_valid,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] r_data_CPU
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               owner_q, owner_d;
  logic               killed_q, killed_d;
  logic               valid_q, valid_d;
  req_fields_t        fields_q, fields_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic [DATA_W-1:0]  resp0_rdata_q, resp0_rdata_d;
  logic [DATA_W-1:0]  resp1_rdata_q, resp1_rdata_d;

  logic               req0_eff_c;
  logic               arb_en_c;
  logic               grant0_c, grant1_c;
  logic               done_c, kill_now_c;
  req_fields_t        req0_fields_c, req1_fields_c;

  assign req0_fields_c = '{op: req0_op, addr: req0_addr, signed_ext: req0_signed_ext,
                           write_type: req0_write_type, wdata: req0_wdata};
  assign req1_fields_c = '{op: req1_op, addr: req1_addr, signed_ext: req1_signed_ext,
                           write_type: req1_write_type, wdata: req1_wdata};

  // A flushing LSU is invisible to arbitration
  assign req0_eff_c = req0_valid && !flush_by_writeback;
  assign arb_en_c   = (state_q == ARB_IDLE);

  dcache_port_arbiter_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_pick (
    .clk        (clk),
    .rstn       (rstn),
    .arb_en_i   (arb_en_c),
    .req0_i     (req0_eff_c),
    .req1_i     (req1_valid),
    .grant0_c_o (grant0_c),
    .grant1_c_o (grant1_c)
  );

  assign req0_ready  = grant0_c;
  assign req1_ready  = grant1_c;

  assign valid       = valid_q;
  assign op          = fields_q.op;
  assign addr        = fields_q.addr;
  assign signed_ext  = fields_q.signed_ext;
  assign write_type  = fields_q.write_type;
  assign w_data_CPU  = fields_q.wdata;
  assign resp0_valid = resp0_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_rdata = resp1_rdata_q;

  // Next-state, latch, kill and response logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    killed_d      = killed_q;
    valid_d       = valid_q;
    fields_d      = fields_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_rdata_d = resp0_rdata_q;
    resp1_rdata_d = resp1_rdata_q;
    done_c        = 1'b0;
    kill_now_c    = (state_q != ARB_IDLE) && (owner_q == PORT_LSU) && flush_by_writeback;

    case (state_q)
      ARB_IDLE: begin
        if (grant0_c || grant1_c) begin
          owner_d  = grant1_c ? PORT_SB : PORT_LSU;
          fields_d = grant1_c ? req1_fields_c : req0_fields_c;
          killed_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (addr_valid) begin
          valid_d = 1'b0;
          if (data_valid) begin
            done_c = 1'b1;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (data_valid) begin
          done_c = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (kill_now_c) begin
      killed_d = 1'b1;
    end

    // Killed transactions complete silently
    if (done_c) begin
      state_d = ARB_IDLE;
      if (!(killed_q || kill_now_c)) begin
        if (owner_q == PORT_SB) begin
          resp1_valid_d = 1'b1;
          resp1_rdata_d = r_data_CPU;
        end else begin
          resp0_valid_d = 1'b1;
          resp0_rdata_d = r_data_CPU;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ARB_IDLE;
      owner_q       <= PORT_LSU;
      killed_q      <= 1'b0;
      valid_q       <= 1'b0;
      fields_q      <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      killed_q      <= killed_d;
      valid_q       <= valid_d;
      fields_q      <= fields_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a transaction-level model predicts
// grants, cache requests and responses; monitors compare what the DUT presents.
`timescale 1ns/1ps
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush_by_writeback = 1'b0;
  logic        req0_valid = 1'b0, req0_op = 1'b0, req0_signed_ext = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [3:0]  req0_write_type = '0;
  logic        req1_valid = 1'b0, req1_op = 1'b0, req1_signed_ext = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req1_write_type = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        valid, op, signed_ext;
  logic [31:0] addr, w_data_CPU;
  logic [3:0]  write_type;
  logic        addr_valid = 1'b0, data_valid = 1'b0;
  logic [31:0] r_data_CPU = '0;

  always #5 clk = ~clk;

  dcache_port_arbiter dut (
    .clk(clk), .rstn(rstn), .flush_by_writeback(flush_by_writeback),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr),
    .req0_signed_ext(req0_signed_ext), .req0_write_type(req0_write_type),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr),
    .req1_signed_ext(req1_signed_ext), .req1_write_type(req1_write_type),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .valid(valid), .op(op), .addr(addr), .signed_ext(signed_ext),
    .write_type(write_type), .w_data_CPU(w_data_CPU),
    .addr_valid(addr_valid), .data_valid(data_valid), .r_data_CPU(r_data_CPU)
  );

  typedef struct { logic port; req_fields_t f; int cyc; } exp_req_t;
  typedef struct { logic port; logic [31:0] rdata; int cyc; } exp_resp_t;

  exp_req_t  req_q[$];
  exp_resp_t resp_q[$];
  logic      dut_grants[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int        cyc = 0;

  // Model state: 0 idle, 1 request phase, 2 waiting for data
  int   m_phase = 0;
  int   m_starve = 0;
  logic m_owner = 1'b0;
  logic m_killed = 1'b0;
  logic m_g0 = 1'b0, m_g1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: arbitration rules and transaction bookkeeping
  always @(negedge clk) begin
    logic r0, r1, g0, g1, done;
    exp_req_t  er;
    exp_resp_t ep;
    if (!rstn) begin
      m_phase = 0; m_starve = 0; m_killed = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0;
      req_q.delete();
      resp_q.delete();
    end else begin
      r0 = req0_valid && !flush_by_writeback;
      r1 = req1_valid;
      g0 = 1'b0; g1 = 1'b0; done = 1'b0;
      chk("valid_level", 32'(valid), 32'(m_phase == 1));
      if (m_phase == 0) begin
        g1 = r1 && (!r0 || m_starve == int'(STARVE_LIMIT_DEF));
        g0 = r0 && !g1;
      end
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      if (req0_ready) dut_grants.push_back(1'b0);
      if (req1_ready) dut_grants.push_back(1'b1);
      m_g0 = g0; m_g1 = g1;
      if (g0 || g1) begin
        er.port = g1;
        er.f = g1 ? '{op: req1_op, addr: req1_addr, signed_ext: req1_signed_ext,
                      write_type: req1_write_type, wdata: req1_wdata}
                  : '{op: req0_op, addr: req0_addr, signed_ext: req0_signed_ext,
                      write_type: req0_write_type, wdata: req0_wdata};
        er.cyc = cyc + 1;
        req_q.push_back(er);
        m_owner = g1; m_killed = 1'b0; m_phase = 1;
        if (g1 || !req1_valid) m_starve = 0;
        else if (m_starve < int'(STARVE_LIMIT_DEF)) m_starve = m_starve + 1;
      end else if (m_phase != 0) begin
        if (flush_by_writeback && m_owner == 1'b0) m_killed = 1'b1;
        if (m_phase == 1 && addr_valid) begin
          if (data_valid) done = 1'b1;
          else m_phase = 2;
        end else if (m_phase == 2 && data_valid) begin
          done = 1'b1;
        end
        if (done) begin
          m_phase = 0;
          if (!m_killed) begin
            ep.port = m_owner; ep.rdata = r_data_CPU; ep.cyc = cyc + 1;
            resp_q.push_back(ep);
          end
        end
      end
    end
  end

  // Cache-side monitor: request fields and grant-to-valid latency
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_req_t e;
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        if (req_q.size() == 0) begin
          fail_evt("unexpected_cache_valid");
        end else begin
          e = req_q[0];
          chk("cache_op", 32'(op), 32'(e.f.op));
          chk("cache_addr", addr, e.f.addr);
          chk("cache_signed_ext", 32'(signed_ext), 32'(e.f.signed_ext));
          chk("cache_write_type", 32'(write_type), 32'(e.f.write_type));
          chk("cache_wdata", w_data_CPU, e.f.wdata);
          if (!prev_valid) chk("valid_latency", 32'(cyc), 32'(e.cyc));
          if (addr_valid) void'(req_q.pop_front());
        end
      end
      prev_valid = valid;
    end
  end

  // Response monitor: routing, data and timing of resp pulses
  always @(negedge clk) begin
    exp_resp_t e;
    if (rstn) begin
      while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
        fail_evt("missing_resp");
        void'(resp_q.pop_front());
      end
      if (resp0_valid && resp1_valid) begin
        fail_evt("both_resp_valid");
      end else if (resp0_valid || resp1_valid) begin
        if (resp_q.size() == 0) begin
          fail_evt("unexpected_resp");
        end else begin
          e = resp_q.pop_front();
          chk("resp_port", 32'(resp1_valid), 32'(e.port));
          chk("resp_rdata", resp1_valid ? resp1_rdata : resp0_rdata, e.rdata);
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic o, input logic [31:0] a);
    req0_valid = v; req0_op = o; req0_addr = a;
    req0_signed_ext = 1'($urandom_range(0, 1));
    req0_write_type = 4'($urandom_range(0, 15));
    req0_wdata = $urandom;
  endtask

  task automatic set_req1(input logic v, input logic o, input logic [31:0] a);
    req1_valid = v; req1_op = o; req1_addr = a;
    req1_signed_ext = 1'($urandom_range(0, 1));
    req1_write_type = o ? 4'b1111 : 4'($urandom_range(0, 15));
    req1_wdata = $urandom;
  endtask

  // Port-0 read: grant, addr_valid two cycles later, then enter WAIT
  task automatic start_p0_read_to_wait(input logic [31:0] a);
    tick(); set_req0(1'b1, 1'b0, a);
    tick(); req0_valid = 1'b0;
    tick(); addr_valid = 1'b1;
    tick(); addr_valid = 1'b0;
  endtask

  logic exp_order [10];
  int   n;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_signed_ext", 32'(signed_ext), 32'd0);
    chk("rst_write_type", 32'(write_type), 32'd0);
    chk("rst_wdata", w_data_CPU, 32'd0);
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst_resp0_rdata", resp0_rdata, 32'd0);
    chk("rst_resp1_rdata", resp1_rdata, 32'd0);
    rstn = 1'b1;

    // Port-0 read alone
    start_p0_read_to_wait(32'h0000_1000);
    tick(); data_valid = 1'b1; r_data_CPU = 32'hDEAD_BEEF;
    tick(); data_valid = 1'b0;
    chk("p0_read_resp0_valid", 32'(resp0_valid), 32'd1);
    chk("p0_read_resp0_rdata", resp0_rdata, 32'hDEAD_BEEF);
    chk("p0_read_resp1_valid", 32'(resp1_valid), 32'd0);

    // Both ports held high, same-cycle handshake: starvation grant order
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dut_grants.delete();
    n = 0;
    while (dut_grants.size() < 10 && n < 100) begin
      tick();
      set_req0(1'b1, 1'b0, 32'h0000_2000);
      set_req1(1'b1, 1'b1, 32'h0000_3000);
      addr_valid = (m_phase == 1);
      data_valid = (m_phase == 1);
      r_data_CPU = $urandom;
      n++;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; addr_valid = 1'b0; data_valid = 1'b0;
    if (dut_grants.size() < 10) fail_evt("grant_order_timeout");
    else for (int i = 0; i < 10; i++) chk($sformatf("grant_order_%0d", i), 32'(dut_grants[i]), 32'(exp_order[i]));

    // Flush in WAIT: response suppressed, next grant normal
    start_p0_read_to_wait(32'h0000_4000);
    flush_by_writeback = 1'b1;
    tick(); flush_by_writeback = 1'b0; data_valid = 1'b1; r_data_CPU = 32'h1234_5678;
    tick(); data_valid = 1'b0;
    chk("flush_wait_no_resp0", 32'(resp0_valid), 32'd0);

    // Port-1 write with flush during REQ still responds
    tick(); set_req1(1'b1, 1'b1, 32'h0000_5000);
    tick(); req1_valid = 1'b0; flush_by_writeback = 1'b1;
    tick(); flush_by_writeback = 1'b0; addr_valid = 1'b1; data_valid = 1'b1; r_data_CPU = 32'h0BAD_F00D;
    tick(); addr_valid = 1'b0; data_valid = 1'b0;
    chk("p1_flush_resp1_valid", 32'(resp1_valid), 32'd1);

    // Asynchronous reset mid-WAIT
    start_p0_read_to_wait(32'h0000_6000);
    #2 rstn = 1'b0;
    #1 chk("async_rst_valid", 32'(valid), 32'd0);
    tick(); rstn = 1'b1;
    repeat (3) begin
      tick();
      chk("async_rst_no_resp0", 32'(resp0_valid), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!req0_valid || m_g0)
        set_req0(1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)), $urandom);
      if (!req1_valid || m_g1)
        set_req1(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)), $urandom);
      flush_by_writeback = 1'($urandom_range(0, 99) < 12);
      addr_valid = 1'b0;
      data_valid = 1'b0;
      if (m_phase == 1) begin
        addr_valid = 1'($urandom_range(0, 1));
        data_valid = addr_valid && ($urandom_range(0, 2) == 0);
      end else if (m_phase == 2) begin
        data_valid = 1'($urandom_range(0, 2) == 0);
      end
      r_data_CPU = $urandom;
    end

    // Drain
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; flush_by_writeback = 1'b0;
    repeat (10) begin
      addr_valid = (m_phase == 1);
      data_valid = (m_phase != 0);
      r_data_CPU = $urandom;
      tick();
    end
    addr_valid = 1'b0; data_valid = 1'b0;
    repeat (3) tick();
    chk("drain_req_q_empty", 32'(req_q.size()), 32'd0);
    chk("drain_resp_q_empty", 32'(resp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single data-cache request port between two requesters: port 0 is the exe-stage load/store unit and port 1 is the store-buffer / cache-op drain. The arbiter grants one requester at a time, sequences the cache address and data handshakes with one transaction outstanding, and routes the read data back to the owner. A writeback flush squashes port-0 traffic without breaking the cache handshake.

## Interface
- STARVE_LIMIT, 4: number of consecutive port-0 grants after which a waiting port 1 wins the next arbitration.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- flush_by_writeback  in  1  squash all port-0 traffic (pending and in flight).
- reqN_valid  in  1  requester N (N = 0, 1) has a request.
- reqN_op  in  1  write 1, read 0.
- reqN_addr  in  32  byte address.
- reqN_signed_ext  in  1  sign-extend read data.
- reqN_write_type  in  4  byte write enable.
- reqN_wdata  in  32  write data.
- reqN_ready  out  1  combinational; request accepted this cycle.
- respN_valid  out  1  one-cycle pulse; transaction done.
- respN_rdata  out  32  read data, valid with respN_valid.
- valid  out  1  cache request valid.
- op, addr, signed_ext, write_type, w_data_CPU  out  1/32/1/4/32  latched request fields driven to the cache.
- addr_valid  in  1  cache accepted address (and write data).
- data_valid  in  1  read data returned / write completed.
- r_data_CPU  in  32  read data from the cache.

## Operation
- States: IDLE, REQ (valid high, waiting for addr_valid), WAIT (waiting for data_valid).
- IDLE arbitration:
  - Port 0 wins by default.
  - Port 1 wins if req1_valid, and either req0_valid is low or starve_cnt == STARVE_LIMIT.
  - req0 is treated as invalid while flush_by_writeback is high.
  - The winner's reqN_ready is high for that cycle. Its fields and owner id are latched, killed is cleared, and the state goes to REQ.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a port-0 grant while req1_valid is high.
  - Clears on any port-1 grant, or on any grant while req1_valid is low.
- REQ:
  - valid = 1 with the latched fields, held stable until addr_valid.
  - addr_valid with data_valid low: go to WAIT.
  - addr_valid and data_valid in the same cycle: complete and go to IDLE.
- WAIT:
  - data_valid completes the transaction and returns the state to IDLE.
- Completion: respOwner_valid pulses for one cycle with respOwner_rdata = r_data_CPU, unless killed is set; if killed, nothing is reported.
- Flush:
  - flush_by_writeback while owner == 0 in REQ or WAIT sets killed.
  - The request is never withdrawn; the handshake runs to completion, then the response is discarded.
  - Port-1 transactions are never killed.
- No grant is made in REQ or WAIT. reqN_ready = 0 there.

## Timing
- Reset values:
  - state IDLE, starve_cnt 0, killed 0.
  - valid, op, signed_ext, respN_valid = 0.
  - addr, w_data_CPU, respN_rdata = 0; write_type = 0.
- Grant in cycle T puts valid high in T+1.
- Minimum occupancy is 2 cycles (grant, then REQ with addr_valid and data_valid together).
- The next grant is possible in the cycle after completion.
- resp is registered and appears in the cycle after data_valid.
- A flush in the same cycle as completion suppresses that port-0 response.
- An asynchronous reset mid-transaction returns to IDLE immediately. The in-flight cache transaction is abandoned; the cache is reset by the same rstn.

## Structure
- Shared package holds:
  - The state encoding (ARB_IDLE, ARB_REQ, ARB_WAIT).
  - The request field bundle (op, addr, signed_ext, write_type, wdata).
  - Port id constants PORT_LSU = 0, PORT_SB = 1.
- One sub-module, arb_pick: combinational starvation-aware priority pick plus the starve_cnt register.
- The FSM, latch and response logic live in the top module.

## Test plan
- Port-0 read alone: req0 read addr 0x1000 at T; addr_valid at T+2, data_valid at T+4 with 0xDEADBEEF -> resp0_valid at T+5 with 0xDEADBEEF; resp1_valid stays 0.
- Simultaneous requests, STARVE_LIMIT 4: req0 and req1 held high -> grant order 0,0,0,0,1,0,0,0,0,1.
- Flush in WAIT: port-0 read granted, flush_by_writeback pulsed in WAIT -> valid is not dropped early; on data_valid, no resp0_valid; next grant proceeds normally.
- Port-1 write with flush: req1 write_type 4'b1111, flush asserted in REQ -> resp1_valid still pulses after data_valid.
- Same-cycle handshake: addr_valid and data_valid together in REQ -> return to IDLE with a single resp pulse; a waiting req is granted the next cycle.
- Async reset mid-WAIT: rstn low between edges -> valid 0 and state IDLE immediately, no resp pulse afterward.
